// File: rtl/game_pkg.sv
// Shared constants for the rhythm-game lane datapath.
// Screen x positions are 9 bits; EMPTY_X never matches a hit window.
package game_pkg;
    localparam int X_WIDTH = 9;
    localparam logic [X_WIDTH-1:0] EMPTY_X = 9'h1FF;
    localparam int EPS = 10;
    localparam int X_START_DEF = 319;
endpackage

// File: rtl/target_queue.sv
// Circular oldest-first queue of target x positions with bulk decrement.
// head_x, count and nonempty are registered from next-state values.
module target_queue
    import game_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int SPEED   = 2,
    parameter int X_START = X_START_DEF
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               push,
    input  logic               pop,
    input  logic               dec,
    output logic [X_WIDTH-1:0] head_x,
    output logic [2:0]         count,
    output logic               nonempty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [X_WIDTH-1:0] SPD = X_WIDTH'(SPEED);
    localparam logic [X_WIDTH-1:0] XS = X_WIDTH'(X_START);

    typedef logic [PW-1:0] ptr_t;

    logic [X_WIDTH-1:0] mem_q [DEPTH];
    logic [X_WIDTH-1:0] mem_n [DEPTH];
    ptr_t head_q, head_n, tail;
    logic [2:0] cnt_n;

    function automatic ptr_t wrap(input int v);
        return ptr_t'((v >= DEPTH) ? v - DEPTH : v);
    endfunction

    // Pop before push so a full queue can pop and push into the same slot.
    always_comb begin
        mem_n  = mem_q;
        head_n = head_q;
        tail   = wrap(int'(head_q) + int'(count));
        if (dec) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i] >= SPD) mem_n[i] = mem_q[i] - SPD;
            end
        end
        if (pop) begin
            mem_n[head_q] = EMPTY_X;
            head_n = wrap(int'(head_q) + 1);
        end
        if (push) mem_n[tail] = XS;
        cnt_n = count + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= EMPTY_X;
            head_q   <= '0;
            count    <= '0;
            nonempty <= 1'b0;
            head_x   <= EMPTY_X;
        end else begin
            mem_q    <= mem_n;
            head_q   <= head_n;
            count    <= cnt_n;
            nonempty <= (cnt_n != 3'd0);
            head_x   <= (cnt_n != 3'd0) ? mem_n[head_n] : EMPTY_X;
        end
    end
endmodule

// File: rtl/note_scroller.sv
// One lane of scrolling note targets: arbitrates tick, hit and spawn,
// and raises one-cycle miss and overflow pulses.
module note_scroller
    import game_pkg::*;
#(
    parameter int X_START = X_START_DEF,
    parameter int SPEED   = 2,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       frame_tick,
    input  logic       spawn,
    input  logic       hit,
    output logic [8:0] stream,
    output logic       valid,
    output logic [2:0] count,
    output logic       miss,
    output logic       overflow
);
    localparam logic [X_WIDTH-1:0] SPD = X_WIDTH'(SPEED);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic do_hit, do_miss, pop, push, full, drop;

    // A hit wins over a scroll-off, so at most one head leaves per cycle.
    always_comb begin
        do_hit  = hit & valid;
        do_miss = frame_tick & valid & ~hit & (stream < SPD);
        pop     = do_hit | do_miss;
        full    = (count == DEPTH_C);
        push    = spawn & (~full | pop);
        drop    = spawn & full & ~pop;
    end

    target_queue #(
        .DEPTH  (DEPTH),
        .SPEED  (SPEED),
        .X_START(X_START)
    ) u_queue (
        .clk     (clk),
        .reset_b (reset_b),
        .push    (push),
        .pop     (pop),
        .dec     (frame_tick),
        .head_x  (stream),
        .count   (count),
        .nonempty(valid)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            miss     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            miss     <= do_miss;
            overflow <= drop;
        end
    end
endmodule

// File: tb/tb_note_scroller.sv
// Self-checking bench for note_scroller: vector table, directed
// corner sequences and random traffic against a queue-based model.
module tb_note_scroller;
    localparam int XS = 319;
    localparam int SP = 2;
    localparam int DP = 4;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       frame_tick = 1'b0;
    logic       spawn = 1'b0;
    logic       hit = 1'b0;
    logic [8:0] stream;
    logic       valid;
    logic [2:0] count;
    logic       miss;
    logic       overflow;

    int total = 0;
    int bad = 0;

    int q[$];
    bit m_miss = 1'b0;
    bit m_ovf = 1'b0;

    typedef struct {
        bit t;
        bit s;
        bit h;
        int st;
        int cn;
        bit ov;
    } vec_t;

    vec_t tbl[13];

    always #5 clk = ~clk;

    note_scroller #(
        .X_START(XS),
        .SPEED  (SP),
        .DEPTH  (DP)
    ) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .frame_tick(frame_tick),
        .spawn     (spawn),
        .hit       (hit),
        .stream    (stream),
        .valid     (valid),
        .count     (count),
        .miss      (miss),
        .overflow  (overflow)
    );

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Reference: a list of x positions, oldest first.
    function automatic void step(input bit t, input bit s, input bit h);
        m_miss = 1'b0;
        m_ovf = 1'b0;
        if (h && q.size() > 0) begin
            void'(q.pop_front());
        end else if (t && q.size() > 0 && q[0] < SP) begin
            void'(q.pop_front());
            m_miss = 1'b1;
        end
        if (t) begin
            foreach (q[i]) if (q[i] >= SP) q[i] = q[i] - SP;
        end
        if (s) begin
            if (q.size() < DP) q.push_back(XS);
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic chk_model(input string nm);
        chk({nm, ".stream"}, int'(stream), (q.size() > 0) ? q[0] : 511);
        chk({nm, ".valid"}, int'(valid), (q.size() > 0) ? 1 : 0);
        chk({nm, ".count"}, int'(count), q.size());
        chk({nm, ".miss"}, int'(miss), int'(m_miss));
        chk({nm, ".ovf"}, int'(overflow), int'(m_ovf));
    endtask

    task automatic cyc(input bit t, input bit s, input bit h);
        @(negedge clk);
        frame_tick = t;
        spawn = s;
        hit = h;
        @(posedge clk);
        step(t, s, h);
        #1;
        frame_tick = 1'b0;
        spawn = 1'b0;
        hit = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_b = 1'b0;
        q.delete();
        m_miss = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{0, 1, 0, 319, 1, 0};
        tbl[1]  = '{1, 0, 0, 317, 1, 0};
        tbl[2]  = '{1, 1, 0, 315, 2, 0};
        tbl[3]  = '{0, 0, 1, 319, 1, 0};
        tbl[4]  = '{0, 0, 1, 511, 0, 0};
        tbl[5]  = '{0, 0, 1, 511, 0, 0};
        tbl[6]  = '{0, 1, 0, 319, 1, 0};
        tbl[7]  = '{0, 1, 0, 319, 2, 0};
        tbl[8]  = '{0, 1, 0, 319, 3, 0};
        tbl[9]  = '{0, 1, 0, 319, 4, 0};
        tbl[10] = '{0, 1, 0, 319, 4, 1};
        tbl[11] = '{0, 1, 1, 319, 4, 0};
        tbl[12] = '{0, 0, 0, 319, 4, 0};

        repeat (2) @(negedge clk);
        chk("rst.stream", int'(stream), 511);
        chk("rst.valid", int'(valid), 0);
        chk("rst.count", int'(count), 0);
        chk("rst.miss", int'(miss), 0);
        chk("rst.ovf", int'(overflow), 0);
        reset_b = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].t, tbl[i].s, tbl[i].h);
            chk($sformatf("tbl%0d.stream", i), int'(stream), tbl[i].st);
            chk($sformatf("tbl%0d.count", i), int'(count), tbl[i].cn);
            chk($sformatf("tbl%0d.ovf", i), int'(overflow), int'(tbl[i].ov));
            chk($sformatf("tbl%0d.miss", i), int'(miss), 0);
        end

        // Full scroll-off of a single target.
        do_reset();
        cyc(0, 1, 0);
        chk("scroll.first", int'(stream), XS);
        for (int k = 1; k <= 159; k++) begin
            cyc(1, 0, 0);
            chk($sformatf("scroll%0d.x", k), int'(stream), XS - SP * k);
            chk($sformatf("scroll%0d.valid", k), int'(valid), 1);
            chk($sformatf("scroll%0d.miss", k), int'(miss), 0);
        end
        cyc(1, 0, 0);
        chk("scroll.miss", int'(miss), 1);
        chk("scroll.count", int'(count), 0);
        chk("scroll.empty", int'(stream), 511);
        cyc(0, 0, 0);
        chk("scroll.miss_once", int'(miss), 0);

        // Hit near the left edge.
        do_reset();
        cyc(0, 1, 0);
        repeat (157) cyc(1, 0, 0);
        chk("hit5.x", int'(stream), 5);
        cyc(0, 0, 1);
        chk("hit5.count", int'(count), 0);
        chk("hit5.miss", int'(miss), 0);
        chk("hit5.empty", int'(stream), 511);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 0);
            chk($sformatf("hit5.after%0d", k), int'(miss), 0);
        end

        // Hit and tick together on a head at x=1.
        do_reset();
        cyc(0, 1, 0);
        cyc(1, 1, 0);
        repeat (158) cyc(1, 0, 0);
        chk("x1.head", int'(stream), 1);
        chk("x1.count", int'(count), 2);
        cyc(1, 0, 1);
        chk("x1.second", int'(stream), 1);
        chk("x1.count_after", int'(count), 1);
        chk("x1.miss", int'(miss), 0);

        // Asynchronous reset between edges with live targets.
        do_reset();
        repeat (3) cyc(0, 1, 0);
        chk("ar.count_before", int'(count), 3);
        #2;
        reset_b = 1'b0;
        #1;
        chk("ar.count", int'(count), 0);
        chk("ar.valid", int'(valid), 0);
        chk("ar.stream", int'(stream), 511);
        q.delete();
        m_miss = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        cyc(0, 1, 0);
        chk("ar.respawn", int'(stream), XS);
        chk("ar.recount", int'(count), 1);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 63) == 0);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/note_scroller.md
NOTE_SCROLLER -- requirements
Module: note_scroller

Interface
REQ-001 Parameter X_START, default 319, spawn x position of a new target in pixels.
REQ-002 Parameter SPEED, default 2, pixels subtracted from every target per frame_tick.
REQ-003 Parameter DEPTH, default 4, maximum live targets per lane.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset_b  input  1  reset, asynchronous, active-low.
REQ-006 frame_tick  input  1  one-cycle pulse per display frame; advances all targets.
REQ-007 spawn  input  1  one-cycle request to add a target at X_START.
REQ-008 hit  input  1  one-cycle pulse from the lane's hit detector; consumes the head target.
REQ-009 stream  output  9  x position of the head (oldest) target; 9'h1FF when empty.
REQ-010 valid  output  1  high when at least one target is live.
REQ-011 count  output  3  number of live targets, 0..DEPTH.
REQ-012 miss  output  1  one-cycle pulse when the head target scrolls off without a hit.
REQ-013 overflow  output  1  one-cycle pulse when a spawn is dropped because the queue is full.

Function
REQ-014 Targets shall be held oldest-first in an ordered queue of DEPTH 9-bit x entries; stream shall always present the oldest entry.
REQ-015 All outputs shall be registered; an event sampled in cycle N shall be visible on the outputs in cycle N+1.
REQ-016 On frame_tick, each live entry with x >= SPEED shall become x - SPEED; no entry shall wrap below 0.
REQ-017 On frame_tick with head x < SPEED and no hit in the same cycle, the head shall be removed and miss shall pulse for exactly one cycle.
REQ-018 On hit with valid high, the head shall be removed with no miss; on hit with valid low, hit shall be ignored.
REQ-019 hit and frame_tick in the same cycle: the head is removed by the hit, and the remaining entries are decremented; miss shall not pulse.
REQ-020 On spawn with count < DEPTH, a new entry at X_START shall be appended at the tail; it shall not be decremented by a frame_tick in the same cycle.
REQ-021 On spawn with count = DEPTH and no removal in the same cycle, spawn shall be dropped and overflow shall pulse for one cycle.
REQ-022 On spawn with count = DEPTH and a removal (hit or miss) in the same cycle, the spawn shall be accepted; count shall stay at DEPTH.
REQ-023 count shall equal previous count + accepted spawn - removal, and shall never exceed DEPTH or go below 0.
REQ-024 When empty, stream shall be 9'h1FF, so no downstream proximity check can report a hit.
REQ-025 At most one entry shall be removed per cycle.

Reset
REQ-026 While reset_b is low, count = 0, valid = 0, stream = 9'h1FF, miss = 0, overflow = 0, and all entries are invalid, regardless of clk.
REQ-027 Reset asserted mid-scroll shall discard all live targets; after release, the first accepted spawn shall appear as the sole head at X_START.
REQ-028 Inputs in the cycle reset_b deasserts shall have no effect.

Structure
REQ-029 Shared package game_pkg shall hold X_WIDTH = 9, EMPTY_X = 9'h1FF, the hit window EPS = 10, and the default X_START.
REQ-030 Queue storage, head/tail pointers and count shall live in one sub-module, target_queue, supporting a bulk decrement; note_scroller owns the tick/hit/spawn arbitration and the miss and overflow pulses.

Verification
REQ-031 Reset, single spawn, then 159 frame_ticks with SPEED=2 -> stream 319, then 317 ... down to 1, valid=1; the 160th tick -> miss pulses once, count=0, stream=9'h1FF.
REQ-032 Spawn, ticks until stream=5, then hit -> next cycle count=0, no miss pulse, and further ticks produce no miss.
REQ-033 Four spawns on separate cycles, then a fifth spawn -> count=4, overflow pulses once; a fifth spawn coincident with a hit -> accepted, count stays 4, no overflow.
REQ-034 Head at x=1 with hit and frame_tick in the same cycle -> head removed, miss=0, second entry decremented by 2.
REQ-035 Hit while empty -> no state change, stream=9'h1FF; reset_b pulled low asynchronously between clock edges with 3 live targets -> outputs clear immediately, count=0.
